operand_skewer: RTL

Parametrised operand skewer/deskewer for the systolic array datapath; successor to the fixed-depth per-row shift-register skewer. Delays lane i of a NUM_LANES-wide vector by a per-lane staircase (ascending for skew at the array input, descending for deskew at the array output). Adds a valid/ready handshake, per-lane valid tracking with zero fill, backpressure, and tile-end auto-drain, so PEs see zeros rather than stale data on unused slots.

---
 rtl/operand_skewer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/operand_skewer.sv
// ---------------------------------------------------------------------------
// operand_skewer
//   Per-lane staircase delay for the systolic array datapath. Lane i of the
//   input vector is delayed by D_i advancing cycles. D_i ascends with the
//   lane index for input skew and descends for output deskew. A small FSM
//   tracks tile boundaries: after the last vector of a tile is accepted, it
//   stops taking input for DMAX cycles so that bubbles push the tile out
//   (auto-drain). It pulses tile_done when the deepest lane shows the last
//   element. Invalid pipeline slots always carry zero data, so the PEs see
//   zeros rather than stale operands.
//
// Ports
//   clk, reset   clock and asynchronous active-high reset
//   flush        synchronous clear of the lane pipelines and the FSM
//   in_valid / in_ready / in_last / in_data[NUM_LANES]
//                input vector handshake; in_last marks the end of a tile
//   out_ready    advance enable; 0 freezes the whole block
//   out_valid[NUM_LANES] / out_data[NUM_LANES]
//                skewed lanes; data is zero when the lane is invalid
//   busy         FSM not idle, or some valid slot in any lane
//   tile_done    one-cycle pulse aligned with the tile's final output
// ---------------------------------------------------------------------------

// One lane: a DEPTH-stage {valid, data} shift register. Data is forced to
// zero on load when valid is low, so the output needs no masking.
module operand_skewer_lane #(
  parameter int DEPTH     = 1,
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 advance,
  input  logic                 load_vld,
  input  logic [DATA_SIZE-1:0] load_data,
  output logic                 out_vld,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 any_vld
);
  logic [DEPTH-1:0]                vld_pipe;
  logic [DEPTH-1:0][DATA_SIZE-1:0] dat_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else if (advance) begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        vld_pipe[s] <= vld_pipe[s-1];
        dat_pipe[s] <= dat_pipe[s-1];
      end
      vld_pipe[0] <= load_vld;
      dat_pipe[0] <= load_vld ? load_data : '0;
    end
  end

  assign out_vld  = vld_pipe[DEPTH-1];
  assign out_data = dat_pipe[DEPTH-1];
  assign any_vld  = |vld_pipe;
endmodule

module operand_skewer #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_SIZE  = 32,
  parameter int BASE_DELAY = 1,
  parameter int DESKEW     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [DATA_SIZE-1:0] in_data [NUM_LANES],
  input  logic                 out_ready,
  output logic [NUM_LANES-1:0] out_valid,
  output logic [DATA_SIZE-1:0] out_data [NUM_LANES],
  output logic                 busy,
  output logic                 tile_done
);
  localparam int DMAX = BASE_DELAY + NUM_LANES - 1;
  localparam int CNTW = $clog2(DMAX + 1);
  // Drain counter value in the final drain cycle, and the one before it.
  // The tile_done flop is set one advancing edge early so that its output
  // lines up with the deepest lane's last element.
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DMAX - 1);
  localparam logic [CNTW-1:0] CNT_PEN  = CNTW'((DMAX >= 2) ? DMAX - 2 : 0);
  localparam bit              ONE_DEEP = (DMAX == 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]           state;
  logic [CNTW-1:0]      cnt;
  logic                 advance, accept;
  logic [NUM_LANES-1:0] lane_busy;

  assign advance  = out_ready & ~flush;
  assign in_ready = out_ready & ~flush & ~reset & (state != DRAIN);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != IDLE) | (|lane_busy);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam int D = (DESKEW != 0) ? BASE_DELAY + NUM_LANES - 1 - i
                                     : BASE_DELAY + i;
    operand_skewer_lane #(.DEPTH(D), .DATA_SIZE(DATA_SIZE)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .advance  (advance),
      .load_vld (accept),
      .load_data(in_data[i]),
      .out_vld  (out_valid[i]),
      .out_data (out_data[i]),
      .any_vld  (lane_busy[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tile_done <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= '0;
      tile_done <= 1'b0;
    end else begin
      // Pulse by default; a stall does not stretch it.
      tile_done <= 1'b0;
      if (advance) begin
        case (state)
          IDLE, STREAM: begin
            if (accept) begin
              if (in_last) begin
                state     <= DRAIN;
                cnt       <= '0;
                // With a single-stage pipe the last element is out next cycle.
                tile_done <= ONE_DEEP;
              end else begin
                state <= STREAM;
              end
            end
          end
          DRAIN: begin
            if (cnt == CNT_LAST) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (!ONE_DEEP && cnt == CNT_PEN) tile_done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
